// File: rtl/logic_unit_if.sv
// logic_unit_if: operand/result handshake bundle for logic_unit_pipe
interface logic_unit_if #(parameter int WIDTH = 8, parameter int CNT_W = 16);
   logic in_valid, in_ready, out_valid, out_ready, zero;
   logic [2:0] op;
   logic [WIDTH-1:0] a, b, y;
   logic [CNT_W-1:0] xfer_cnt;
   modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, y, zero, xfer_cnt);
   modport slave (input in_valid, op, a, b, out_ready, output in_ready, out_valid, y, zero, xfer_cnt);
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: 1-stage bitwise logic unit, valid/ready both sides; LOGIC_UNIT_REDUCE_EN makes op 111 a reduce-AND/OR
module logic_unit_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input logic clk,
   input logic rst_n,
   logic_unit_if.slave bus
);
   logic [WIDTH-1:0] res;
   logic acc, done;
   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign acc = bus.in_valid && bus.in_ready;
   assign done = bus.out_valid && bus.out_ready;
   always_comb begin
      res = '0;
      case (bus.op)
         3'b000: res = bus.a & bus.b;
         3'b001: res = bus.a | bus.b;
         3'b010: res = bus.a ^ bus.b;
         3'b011: res = ~(bus.a & bus.b);
         3'b100: res = ~(bus.a | bus.b);
         3'b101: res = ~(bus.a ^ bus.b);
         3'b110: res = ~bus.a;
`ifdef LOGIC_UNIT_REDUCE_EN
         default: res = WIDTH'({|bus.a, &bus.a});
`else
         default: res = '0;
`endif
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.y <= '0;
         bus.zero <= 1'b1;
         bus.xfer_cnt <= '0;
      end else begin
         bus.out_valid <= acc || (bus.out_valid && !bus.out_ready);
         if (acc) begin
            bus.y <= res;
            bus.zero <= (res == '0);
         end
         if (done) bus.xfer_cnt <= bus.xfer_cnt + CNT_W'(1);
      end
   end
endmodule
